// File: rtl/keystream_combiner.sv
// keystream_combiner
// Packs a serial keystream (LSB-first) into DATA_W-bit key words, XORs each
// complete key word with one plaintext word, and holds the ciphertext word in
// a registered output stage until the consumer takes it. Every input and
// output stream uses a valid/ready handshake.
module keystream_combiner #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ks_bit,
  input  logic              ks_valid,
  output logic              ks_ready,
  input  logic [DATA_W-1:0] pt_data,
  input  logic              pt_valid,
  output logic              pt_ready,
  output logic [DATA_W-1:0] ct_data,
  output logic              ct_valid,
  input  logic              ct_ready,
  input  logic              sync_clr,
  output logic [CNT_W-1:0]  words_done
);

  // bit_cnt runs 0..DATA_W. Values below DATA_W mean the key word is still
  // filling; DATA_W means the key word is complete and waiting for plaintext.
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] BIT_CNT_FULL = BC_W'(DATA_W);

  logic [BC_W-1:0]   bit_cnt_q,    bit_cnt_d;
  logic [DATA_W-1:0] key_q,        key_d;
  logic [DATA_W-1:0] ct_data_q,    ct_data_d;
  logic              ct_valid_q,   ct_valid_d;
  logic [CNT_W-1:0]  words_done_q, words_done_d;

  logic in_hold;
  logic ks_xfer;
  logic pt_xfer;
  logic ct_xfer;

  // State register: reset clears the partial key, any pending ciphertext
  // word and the delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      key_q        <= '0;
      ct_data_q    <= '0;
      ct_valid_q   <= 1'b0;
      words_done_q <= '0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      key_q        <= key_d;
      ct_data_q    <= ct_data_d;
      ct_valid_q   <= ct_valid_d;
      words_done_q <= words_done_d;
    end
  end

  // Output decode: ready signals depend only on registered state, ct_ready
  // and sync_clr, never on the matching valid input.
  always_comb begin
    in_hold  = (bit_cnt_q == BIT_CNT_FULL);
    ks_ready = ~in_hold & ~sync_clr;
    pt_ready = in_hold & ~sync_clr & (~ct_valid_q | ct_ready);
    ks_xfer  = ks_valid & ks_ready;
    pt_xfer  = pt_valid & pt_ready;
    ct_xfer  = ct_valid_q & ct_ready;
  end

  // Key packing: the accepted bit lands at the position given by bit_cnt,
  // so the first bit received becomes the key LSB.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_key_bit
      assign key_d[gi] = (ks_xfer && (bit_cnt_q == BC_W'(gi))) ? ks_bit : key_q[gi];
    end
  endgenerate

  // Next-state logic: sync_clr restarts packing; a plaintext transfer
  // consumes the key word and returns to filling.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (sync_clr) begin
      bit_cnt_d = '0;
    end else if (pt_xfer) begin
      bit_cnt_d = '0;
    end else if (ks_xfer) begin
      bit_cnt_d = bit_cnt_q + BC_W'(1);
    end
  end

  // Output stage: a new word loads on a plaintext transfer (even when the
  // old word leaves in the same cycle, so there is no bubble); otherwise a
  // consumer transfer empties the stage.
  always_comb begin
    ct_data_d  = ct_data_q;
    ct_valid_d = ct_valid_q;
    if (pt_xfer) begin
      ct_data_d  = pt_data ^ key_q;
      ct_valid_d = 1'b1;
    end else if (ct_xfer) begin
      ct_valid_d = 1'b0;
    end
  end

  // Delivered-word counter, saturating at all-ones.
  always_comb begin
    words_done_d = words_done_q;
    if (ct_xfer && (words_done_q != {CNT_W{1'b1}})) begin
      words_done_d = words_done_q + CNT_W'(1);
    end
  end

  assign ct_data    = ct_data_q;
  assign ct_valid   = ct_valid_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_keystream_combiner.sv
// Scoreboard bench for keystream_combiner. Two instances share all stimulus:
// the default-width one and a CNT_W=4 one used for the saturation scenario.
// The driver pushes expected ciphertext when it issues a plaintext transfer;
// a monitor on the falling edge pops and compares on every ct transfer and
// tracks the expected delivered-word count.
module tb_keystream_combiner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ks_bit = 1'b0;
  logic       ks_valid = 1'b0;
  logic [7:0] pt_data = 8'h00;
  logic       pt_valid = 1'b0;
  logic       ct_ready = 1'b0;
  logic       sync_clr = 1'b0;

  logic        ks_ready, pt_ready, ct_valid;
  logic [7:0]  ct_data;
  logic [15:0] words_done;

  logic        ks_ready_s, pt_ready_s, ct_valid_s;
  logic [7:0]  ct_data_s;
  logic [3:0]  words_done_s;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_words = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q_s[$];
  int xfer_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keystream_combiner #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .sync_clr(sync_clr), .words_done(words_done)
  );

  keystream_combiner #(.DATA_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready_s),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready_s),
    .ct_data(ct_data_s), .ct_valid(ct_valid_s), .ct_ready(ct_ready),
    .sync_clr(sync_clr), .words_done(words_done_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer bits k[0..nbits-1], one per accepted ks transfer.
  task automatic feed_key(input logic [7:0] k, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int t;
      ks_bit   = k[i];
      ks_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!(ks_ready && ks_ready_s) && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!(ks_ready && ks_ready_s)) chk("ks_ready_timeout", 32'd0, 32'd1);
      tick();
    end
  endtask

  // Offer one plaintext word; push the expected ciphertext at the transfer.
  task automatic send_pt(input logic [7:0] d, input logic [7:0] exp);
    int t;
    pt_data  = d;
    pt_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!(pt_ready && pt_ready_s) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!(pt_ready && pt_ready_s)) begin
      chk("pt_ready_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(exp);
      exp_q_s.push_back(exp);
    end
    tick();
    pt_valid = 1'b0;
    chk("combine_ct_valid", {31'd0, ct_valid}, 32'd1);
    chk("combine_ct_data", {24'd0, ct_data}, {24'd0, exp});
  endtask

  // Monitor: compare counters every cycle, pop the scoreboard on ct transfers.
  always @(negedge clk) begin
    if (!rst) begin
      chk("words_done", {16'd0, words_done}, exp_words);
      chk("words_done_sat", {28'd0, words_done_s}, (exp_words > 15) ? 32'd15 : exp_words);
    end
    if (rst) begin
      exp_q.delete();
      exp_q_s.delete();
      exp_words = 0;
    end else begin
      if (ct_valid && ct_ready) begin
        if (exp_q.size() == 0) chk("ct_unexpected", {24'd0, ct_data}, 32'hFFFF_FFFF);
        else chk("ct_data", {24'd0, ct_data}, {24'd0, exp_q.pop_front()});
        exp_words++;
        xfer_cyc.push_back(cyc);
      end
      if (ct_valid_s && ct_ready) begin
        if (exp_q_s.size() == 0) chk("ct_sat_unexpected", {24'd0, ct_data_s}, 32'hFFFF_FFFF);
        else chk("ct_data_sat", {24'd0, ct_data_s}, {24'd0, exp_q_s.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k;
    logic [7:0] p;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ks_ready", {31'd0, ks_ready}, 32'd1);
    chk("rst_pt_ready", {31'd0, pt_ready}, 32'd0);
    chk("rst_ct_valid", {31'd0, ct_valid}, 32'd0);
    chk("rst_ct_data", {24'd0, ct_data}, 32'd0);
    tick();

    // Basic combine: key 0x0D, pt 0x41 -> 0x4C
    ct_ready = 1'b1;
    feed_key(8'h0D, 8);
    @(negedge clk);
    chk("hold_ks_ready", {31'd0, ks_ready}, 32'd0);
    tick();
    send_pt(8'h41, 8'h4C);
    ks_valid = 1'b0;
    repeat (3) tick();

    // Streaming: back-to-back words, ct_ready held high
    xfer_cyc.delete();
    feed_key(8'hFF, 8); send_pt(8'h12, 8'hED);
    feed_key(8'h00, 8); send_pt(8'h12, 8'h12);
    feed_key(8'hA5, 8); send_pt(8'h12, 8'hB7);
    feed_key(8'h3C, 8); send_pt(8'h12, 8'h2E);
    ks_valid = 1'b0;
    repeat (3) tick();
    chk("stream_xfers", xfer_cyc.size(), 32'd4);
    if (xfer_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("stream_spacing", xfer_cyc[i] - xfer_cyc[i-1], 32'd9);
    end

    // Backpressure
    ct_ready = 1'b0;
    feed_key(8'h55, 8);
    send_pt(8'hAA, 8'hFF);
    feed_key(8'h0F, 8);
    pt_data  = 8'h33;
    pt_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_pt_ready", {31'd0, pt_ready}, 32'd0);
      chk("bp_ks_ready", {31'd0, ks_ready}, 32'd0);
      chk("bp_ct_data", {24'd0, ct_data}, 32'hFF);
      tick();
    end
    ct_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_pt_ready", {31'd0, pt_ready}, 32'd1);
    if (pt_ready && pt_ready_s) begin
      exp_q.push_back(8'h3C);
      exp_q_s.push_back(8'h3C);
    end
    tick();
    pt_valid = 1'b0;
    ks_valid = 1'b0;
    chk("no_bubble_ct_valid", {31'd0, ct_valid}, 32'd1);
    chk("no_bubble_ct_data", {24'd0, ct_data}, 32'h3C);
    repeat (3) tick();

    // Resync: 5 junk bits, sync_clr with a bit offered, then a clean key
    feed_key(8'h1F, 5);
    sync_clr = 1'b1;
    ks_valid = 1'b1;
    ks_bit   = 1'b1;
    @(negedge clk);
    chk("sync_ks_ready", {31'd0, ks_ready}, 32'd0);
    chk("sync_pt_ready", {31'd0, pt_ready}, 32'd0);
    tick();
    sync_clr = 1'b0;
    feed_key(8'h0D, 8);
    send_pt(8'h41, 8'h4C);
    ks_valid = 1'b0;
    repeat (3) tick();

    // Reset mid-operation: pending ct word plus 3 packed bits
    ct_ready = 1'b0;
    feed_key(8'h0D, 8);
    send_pt(8'h41, 8'h4C);
    feed_key(8'h07, 3);
    ks_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ct_valid", {31'd0, ct_valid}, 32'd0);
    chk("mrst_ks_ready", {31'd0, ks_ready}, 32'd1);
    chk("mrst_pt_ready", {31'd0, pt_ready}, 32'd0);
    tick();
    ct_ready = 1'b1;
    feed_key(8'h0D, 8);
    send_pt(8'h41, 8'h4C);

    // Saturation: 20 further words (21 since reset)
    for (int i = 0; i < 20; i++) begin
      k = 8'(i * 37 + 5);
      p = 8'(i * 11 + 1);
      feed_key(k, 8);
      send_pt(p, k ^ p);
    end
    ks_valid = 1'b0;
    repeat (4) tick();
    chk("final_words_done", {16'd0, words_done}, 32'd21);
    chk("final_words_done_sat", {28'd0, words_done_s}, 32'd15);
    chk("scoreboard_empty", exp_q.size() + exp_q_s.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
